elevator_ctrl_n: RTL and testbench

- Parametrised successor to the 4-floor elevator controller. Serves up to N_FLOORS floors from a latched request set, using a SCAN (collective) policy.
- Adds timed floor-to-floor travel, a timed door dwell and a priority emergency return to floor 0.
- Sits between the debounced car/hall button logic and the floor indicator / door actuator drivers.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_timer.sv | 33 +++
 rtl/elevator_ctrl_n.sv | 167 ++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller: FSM states and direction encoding.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    EMERGENCY
  } state_e;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door-dwell phases.
// done is high whenever the count has reached zero.
module elevator_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over count; counting stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// SCAN elevator controller: latched requests, timed travel and door dwell,
// and an emergency return to floor 0 that overrides everything else.
import elevator_pkg::*;

module elevator_ctrl_n #(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = $clog2(N_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                emergency_btn,
  input  logic [N_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]  floor,
  output logic                door_open,
  output logic                moving_up,
  output logic                moving_down,
  output logic [N_FLOORS-1:0] pending,
  output logic                emergency_active
);

  localparam int MAX_C = max2(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP  = FLOOR_W'(N_FLOORS - 1);

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [N_FLOORS-1:0]   pending_q, pending_d;
  logic                  dir_q, dir_d;

  logic                  tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]         tmr_val, tmr_value;
  logic                  any_above, any_below, go_up, go_dn;

  elevator_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  // scan registered requests above / below the current floor
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor_q) any_above |= pending_q[i];
      if (FLOOR_W'(i) < floor_q) any_below |= pending_q[i];
    end
  end

  // keep going the current way if possible, else reverse
  assign go_up = dir_q ? any_above : (any_above & ~any_below);
  assign go_dn = dir_q ? (any_below & ~any_above) : any_below;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      dir_q     <= UP;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
    end
  end

  // next-state, floor, request latch and timer control
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    pending_d = pending_q | call_req;
    tmr_load  = 1'b0;
    tmr_val   = TRAVEL_LD;
    tmr_en    = 1'b0;

    if (emergency_btn && state_q != EMERGENCY) begin
      // abort whatever is in progress; partial travel is discarded
      state_d   = EMERGENCY;
      pending_d = '0;
      tmr_load  = 1'b1;
    end else begin
      case (state_q)
        IDLE, DOOR_OPEN: begin
          if (state_q == DOOR_OPEN && call_req[floor_q]) begin
            tmr_load = 1'b1;
            tmr_val  = DOOR_LD;
          end else if (state_q == IDLE && pending_q[floor_q]) begin
            state_d  = DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = DOOR_LD;
          end else if (state_q == DOOR_OPEN && !tmr_done) begin
            tmr_en = 1'b1;
          end else if (go_up) begin
            state_d  = MOVE_UP;
            dir_d    = UP;
            tmr_load = 1'b1;
          end else if (go_dn) begin
            state_d  = MOVE_DOWN;
            dir_d    = DOWN;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (tmr_done) begin
            floor_d  = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
            tmr_load = 1'b1;
            // only a request already latched stops the car here
            if (pending_q[floor_d]) begin
              state_d = DOOR_OPEN;
              tmr_val = DOOR_LD;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        EMERGENCY: begin
          pending_d = '0;
          if (floor_q != '0) begin
            if (tmr_done) begin
              floor_d  = floor_q - FLOOR_W'(1);
              tmr_load = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end else if (!emergency_btn) begin
            state_d = IDLE;
            dir_d   = UP;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // the stop being served never stays pending
    if (state_d == DOOR_OPEN) pending_d[floor_d] = 1'b0;
  end

  // Moore outputs decoded from registered state
  always_comb begin
    door_open        = (state_q == DOOR_OPEN) || (state_q == EMERGENCY && floor_q == '0);
    moving_up        = (state_q == MOVE_UP);
    moving_down      = (state_q == MOVE_DOWN) || (state_q == EMERGENCY && floor_q != '0);
    emergency_active = (state_q == EMERGENCY);
    floor            = floor_q;
    pending          = pending_q;
  end

  // travel can never step past either end of the shaft
  always_ff @(posedge clk) begin
    if (reset_n && tmr_done)
      assert (!(state_q == MOVE_UP && floor_q == TOP) && !(state_q == MOVE_DOWN && floor_q == '0));
  end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n with hand-computed expectations.
module tb_elevator_ctrl_n;

  logic       clk, reset_n, emergency_btn;
  logic [7:0] call_req;
  logic [2:0] floor;
  logic       door_open, moving_up, moving_down, emergency_active;
  logic [7:0] pending;

  int n_asrt = 0;
  int n_fail = 0;

  elevator_ctrl_n dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .emergency_btn    (emergency_btn),
    .call_req         (call_req),
    .floor            (floor),
    .door_open        (door_open),
    .moving_up        (moving_up),
    .moving_down      (moving_down),
    .pending          (pending),
    .emergency_active (emergency_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one packed compare: {floor, door, up, down, emergency, pending}
  task automatic chk(input string tag, input logic [2:0] f, input logic d, input logic u,
                     input logic dn, input logic e, input logic [7:0] p);
    logic [14:0] obs, exp;
    obs = {floor, door_open, moving_up, moving_down, emergency_active, pending};
    exp = {f, d, u, dn, e, p};
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed={fl=%0d dr=%b up=%b dn=%b em=%b pend=%h} expected={fl=%0d dr=%b up=%b dn=%b em=%b pend=%h}",
             tag, obs[14:12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
             exp[14:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; emergency_btn = 1'b0; call_req = '0;
    #12;
    chk("reset", 0, 0, 0, 0, 0, 8'h00);
    reset_n = 1'b1;
    step;
    chk("idle_after_reset", 0, 0, 0, 0, 0, 8'h00);

    // single call to floor 5
    call_req = 8'h20; step; call_req = '0;
    chk("t1_latch", 0, 0, 0, 0, 0, 8'h20);
    step;
    chk("t1_move", 0, 0, 1, 0, 0, 8'h20);
    for (int f = 1; f <= 4; f++) begin
      step(4);
      chk("t1_floor", 3'(f), 0, 1, 0, 0, 8'h20);
    end
    step(4); chk("t1_door5", 5, 1, 0, 0, 0, 8'h00);
    step(7); chk("t1_door_last", 5, 1, 0, 0, 0, 8'h00);
    step;    chk("t1_idle", 5, 0, 0, 0, 0, 8'h00);

    // door at floor 3 re-triggered on dwell cycle 6
    call_req = 8'h08; step; call_req = '0;
    chk("t3_latch", 5, 0, 0, 0, 0, 8'h08);
    step;    chk("t3_move", 5, 0, 0, 1, 0, 8'h08);
    step(4); chk("t3_floor4", 4, 0, 0, 1, 0, 8'h08);
    step(4); chk("t3_door", 3, 1, 0, 0, 0, 8'h00);
    step(5);
    call_req = 8'h08; step; call_req = '0;
    chk("t3_recall", 3, 1, 0, 0, 0, 8'h00);
    step(6); chk("t3_held13", 3, 1, 0, 0, 0, 8'h00);
    step;    chk("t3_held14", 3, 1, 0, 0, 0, 8'h00);
    step;    chk("t3_close", 3, 0, 0, 0, 0, 8'h00);

    // SCAN from floor 2 going up with requests {1,4,6}
    reset_n = 1'b0; #3; reset_n = 1'b1;
    step;
    call_req = 8'h04; step; call_req = '0;
    step;
    step(8); chk("t2_at2", 2, 1, 0, 0, 0, 8'h00);
    step(8); chk("t2_idle2", 2, 0, 0, 0, 0, 8'h00);
    call_req = 8'h52; step; call_req = '0;
    chk("t2_latch", 2, 0, 0, 0, 0, 8'h52);
    step;    chk("t2_move", 2, 0, 1, 0, 0, 8'h52);
    step(4); chk("t2_floor3", 3, 0, 1, 0, 0, 8'h52);
    step(4); chk("t2_door4", 4, 1, 0, 0, 0, 8'h42);
    step(8); chk("t2_leave4", 4, 0, 1, 0, 0, 8'h42);
    step(8); chk("t2_door6", 6, 1, 0, 0, 0, 8'h02);
    step(8); chk("t2_reverse", 6, 0, 0, 1, 0, 8'h02);
    step(20); chk("t2_door1", 1, 1, 0, 0, 0, 8'h00);
    step(8); chk("t2_idle1", 1, 0, 0, 0, 0, 8'h00);
    // equal requests both sides: direction left at down picks down
    call_req = 8'h05; step; call_req = '0;
    chk("t2_latch05", 1, 0, 0, 0, 0, 8'h05);
    step;    chk("t2_dir_down", 1, 0, 0, 1, 0, 8'h05);

    // emergency pulse while between floors 4 and 5
    reset_n = 1'b0; #3; reset_n = 1'b1;
    step;
    call_req = 8'h80; step; call_req = '0;
    step;
    step(16); chk("t4_floor4", 4, 0, 1, 0, 0, 8'h80);
    step(2);
    emergency_btn = 1'b1; step; emergency_btn = 1'b0;
    chk("t4_emerg", 4, 0, 0, 1, 1, 8'h00);
    for (int f = 3; f >= 1; f--) begin
      step(4);
      chk("t4_descend", 3'(f), 0, 0, 1, 1, 8'h00);
    end
    step(4); chk("t4_floor0", 0, 1, 0, 0, 1, 8'h00);
    step;    chk("t4_idle", 0, 0, 0, 0, 0, 8'h00);

    // emergency held at floor 0 with all calls asserted
    emergency_btn = 1'b1; call_req = 8'hFF;
    step;    chk("t5_emerg0", 0, 1, 0, 0, 1, 8'h00);
    step(3); chk("t5_hold", 0, 1, 0, 0, 1, 8'h00);
    emergency_btn = 1'b0; call_req = '0;
    step;    chk("t5_release", 0, 0, 0, 0, 0, 8'h00);

    // call landing on the floor-change edge, then async reset at floor 6
    call_req = 8'h80; step; call_req = '0;
    step;
    step(19);
    call_req = 8'h20; step; call_req = '0;
    chk("t6_no_stop5", 5, 0, 1, 0, 0, 8'hA0);
    step(4); chk("t6_floor6", 6, 0, 1, 0, 0, 8'hA0);
    #2; reset_n = 1'b0; #1;
    chk("t6_async_reset", 0, 0, 0, 0, 0, 8'h00);
    #2; reset_n = 1'b1;
    step;    chk("t6_idle", 0, 0, 0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
